// File: rtl/setcc_sequencer.sv
// setcc_sequencer: front end of setcc_logic.
// It owns the architectural flags register, the predicate bit s and a count of
// in-flight flag-writing ALU ops. A SETcc request is captured in IDLE. It waits
// in WAIT while any flag write is still outstanding. In EVAL it presents a
// stable operand set to setcc_logic, and the result is committed into s at the
// end of that cycle.
//
// Handshake: a request transfers on a rising edge where req_valid & req_ready
// are both 1. req_ready depends only on registered state, never on req_valid.
// The request fields are sampled only in that cycle.

module setcc_sequencer #(
    parameter int PEND_W = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flag_issue,
    output logic       pend_full,
    input  logic       alu_flags_we,
    input  logic [3:0] alu_flags,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [3:0] req_mask,
    input  logic [3:0] req_expected,
    output logic       previous_s,
    output logic [2:0] op,
    output logic [3:0] mask,
    output logic [3:0] expected_flags,
    output logic [3:0] current_flags,
    input  logic       s_next,
    output logic       s,
    output logic       s_commit,
    output logic       overflow_err,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EVAL = 2'd2
    } state_e;

    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    state_e            state_q, state_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [3:0]        flags_q, flags_d;
    logic              s_q, s_d;
    logic              commit_q, commit_d;
    logic              ovf_q, ovf_d;
    logic [2:0]        op_q, op_d;
    logic [3:0]        mask_q, mask_d;
    logic [3:0]        expected_q, expected_d;

    logic pend_zero;
    logic issue_ok;
    logic accept;

    assign pend_full = (pend_q == PEND_MAX);
    assign pend_zero = (pend_q == '0);
    // An issue that arrives when the counter is full is dropped, not counted.
    assign issue_ok  = flag_issue & ~pend_full;
    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid & req_ready;

    assign previous_s     = s_q;
    assign s              = s_q;
    assign op             = op_q;
    assign mask           = mask_q;
    assign expected_flags = expected_q;
    assign current_flags  = flags_q;
    assign s_commit       = commit_q;
    assign overflow_err   = ovf_q;
    assign state_o        = state_q;

    // Pending flag-write counter with saturation at both ends, plus sticky overflow.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (flag_issue && pend_full) begin
            ovf_d = 1'b1;
        end
        if (issue_ok && !alu_flags_we) begin
            pend_d = pend_q + PEND_ONE;
        end else if (!issue_ok && alu_flags_we && !pend_zero) begin
            pend_d = pend_q - PEND_ONE;
        end
    end

    // Flags register follows every ALU writeback, whatever the FSM is doing.
    always_comb begin
        flags_d = flags_q;
        if (alu_flags_we) begin
            flags_d = alu_flags;
        end
    end

    // Request FSM: capture in IDLE, stall in WAIT, commit the result in EVAL.
    // The stall decision uses the registered count, so an issue in the accept
    // cycle is younger than the request and does not stall it.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        mask_d     = mask_q;
        expected_d = expected_q;
        s_d        = s_q;
        commit_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d       = req_op;
                    mask_d     = req_mask;
                    expected_d = req_expected;
                    state_d    = pend_zero ? EVAL : WAIT;
                end
            end
            WAIT: begin
                if (pend_zero) begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                s_d      = s_next;
                commit_d = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset drops any captured request without committing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            flags_q    <= '0;
            s_q        <= 1'b0;
            commit_q   <= 1'b0;
            ovf_q      <= 1'b0;
            op_q       <= '0;
            mask_q     <= '0;
            expected_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            flags_q    <= flags_d;
            s_q        <= s_d;
            commit_q   <= commit_d;
            ovf_q      <= ovf_d;
            op_q       <= op_d;
            mask_q     <= mask_d;
            expected_q <= expected_d;
        end
    end

endmodule

// File: tb/tb_setcc_sequencer.sv
// Bench for setcc_sequencer. A small stand-in for setcc_logic drives s_next.
// A reference model tracks outstanding flag writes, the flags value, the request
// in flight and the predicate, and predicts each commit into a queue that a
// separate monitor drains.

module tb_setcc_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       flag_issue;
    logic       pend_full;
    logic       alu_flags_we;
    logic [3:0] alu_flags;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [3:0] req_mask;
    logic [3:0] req_expected;
    logic       previous_s;
    logic [2:0] op;
    logic [3:0] mask;
    logic [3:0] expected_flags;
    logic [3:0] current_flags;
    logic       s_next;
    logic       s;
    logic       s_commit;
    logic       overflow_err;
    logic [1:0] state_o;

    int n_vec = 0;
    int n_err = 0;

    // expected commit: {flags seen during evaluation, committed s}
    logic [4:0] exp_q[$];

    // reference model state
    int         m_pend;
    logic [3:0] m_flags;
    logic       m_s;
    logic       m_ovf;
    logic       m_commit;
    logic       m_held;   // request captured, still stalled
    logic       m_eval;   // request being evaluated this cycle
    logic [2:0] m_op;
    logic [3:0] m_mask;
    logic [3:0] m_exp;

    logic [3:0] prev_flags;

    setcc_sequencer #(.PEND_W(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .flag_issue     (flag_issue),
        .pend_full      (pend_full),
        .alu_flags_we   (alu_flags_we),
        .alu_flags      (alu_flags),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_mask       (req_mask),
        .req_expected   (req_expected),
        .previous_s     (previous_s),
        .op             (op),
        .mask           (mask),
        .expected_flags (expected_flags),
        .current_flags  (current_flags),
        .s_next         (s_next),
        .s              (s),
        .s_commit       (s_commit),
        .overflow_err   (overflow_err),
        .state_o        (state_o)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // stand-in for setcc_logic
    function automatic logic setcc_ref(input logic prev, input logic [2:0] o,
                                       input logic [3:0] m, input logic [3:0] e,
                                       input logic [3:0] f);
        logic hit;
        hit = (((f ^ e) & m) == 4'b0000);
        case (o)
            3'd2:    return ~hit;
            3'd3:    return prev & hit;
            3'd4:    return prev | hit;
            3'd5:    return prev ^ hit;
            3'd6:    return prev;
            default: return hit;
        endcase
    endfunction

    assign s_next = setcc_ref(previous_s, op, mask, expected_flags, current_flags);

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Compare outputs with the model, then advance both across one clock edge.
    task automatic cycle();
        check("req_ready", int'(req_ready), int'(!m_held && !m_eval));
        check("pend_full", int'(pend_full), int'(m_pend == 7));
        check("overflow_err", int'(overflow_err), int'(m_ovf));
        check("s", int'(s), int'(m_s));
        check("previous_s", int'(previous_s), int'(m_s));
        check("current_flags", int'(current_flags), int'(m_flags));
        check("s_commit", int'(s_commit), int'(m_commit));
        check("captured", int'({op, mask, expected_flags}), int'({m_op, m_mask, m_exp}));
        @(posedge clk);
        if (rst) begin
            m_pend = 0; m_flags = 4'd0; m_s = 1'b0; m_ovf = 1'b0; m_commit = 1'b0;
            m_held = 1'b0; m_eval = 1'b0; m_op = 3'd0; m_mask = 4'd0; m_exp = 4'd0;
        end else begin
            logic nxt_held, nxt_eval, ok_issue;
            nxt_held = m_held;
            nxt_eval = 1'b0;
            m_commit = 1'b0;
            if (m_eval) begin
                m_s = setcc_ref(m_s, m_op, m_mask, m_exp, m_flags);
                exp_q.push_back({m_flags, m_s});
                m_commit = 1'b1;
            end else if (m_held) begin
                if (m_pend == 0) begin nxt_held = 1'b0; nxt_eval = 1'b1; end
            end else if (req_valid) begin
                m_op = req_op; m_mask = req_mask; m_exp = req_expected;
                if (m_pend == 0) nxt_eval = 1'b1;
                else nxt_held = 1'b1;
            end
            m_held = nxt_held;
            m_eval = nxt_eval;
            if (alu_flags_we) m_flags = alu_flags;
            if (flag_issue && m_pend == 7) m_ovf = 1'b1;
            ok_issue = flag_issue && (m_pend < 7);
            if (ok_issue && !alu_flags_we) m_pend++;
            else if (!ok_issue && alu_flags_we && m_pend > 0) m_pend--;
        end
        #1;
    endtask

    // driver task: one cycle of stimulus
    task automatic drive(input logic r, input logic iss, input logic we,
                         input logic [3:0] fl, input logic v, input logic [2:0] o,
                         input logic [3:0] m, input logic [3:0] e);
        rst = r; flag_issue = iss; alu_flags_we = we; alu_flags = fl;
        req_valid = v; req_op = o; req_mask = m; req_expected = e;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 4'd0, 0, 3'd0, 4'd0, 4'd0);
    endtask

    // monitor / scoreboard: every commit must match the oldest prediction
    always @(negedge clk) begin
        if (s_commit) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL commit: unexpected commit s=%0d at %0t", s, $time);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                if ({prev_flags, s} !== e) begin
                    n_err++;
                    $display("FAIL commit: got flags=%b s=%0d expected flags=%b s=%0d at %0t",
                             prev_flags, s, e[4:1], e[0], $time);
                end
            end
        end
        prev_flags = current_flags;
    end

    initial begin
        rst = 1'b1; flag_issue = 0; alu_flags_we = 0; alu_flags = 0;
        req_valid = 0; req_op = 0; req_mask = 0; req_expected = 0;
        m_pend = 0; m_flags = 0; m_s = 0; m_ovf = 0; m_commit = 0;
        m_held = 0; m_eval = 0; m_op = 0; m_mask = 0; m_exp = 0;
        @(negedge clk);
        drive(1, 0, 0, 4'd0, 0, 3'd0, 4'd0, 4'd0);
        drive(1, 0, 0, 4'd0, 0, 3'd0, 4'd0, 4'd0);

        // basic latency: flags 0001, request op=1 mask=0001 exp=0001
        drive(0, 0, 1, 4'b0001, 0, 3'd0, 4'd0, 4'd0);
        drive(0, 0, 0, 4'd0, 1, 3'd1, 4'b0001, 4'b0001);
        idle(3);

        // two issues then a stalled request, writebacks at +3 and +5
        drive(0, 1, 0, 4'd0, 0, 3'd0, 4'd0, 4'd0);
        drive(0, 1, 0, 4'd0, 0, 3'd0, 4'd0, 4'd0);
        drive(0, 0, 0, 4'd0, 1, 3'd1, 4'b1000, 4'b1000);
        drive(0, 0, 1, 4'b0100, 0, 3'd0, 4'd0, 4'd0);
        idle(1);
        drive(0, 0, 1, 4'b1000, 0, 3'd0, 4'd0, 4'd0);
        idle(3);

        // issue and accept together: request sees pre-issue flags
        drive(0, 0, 1, 4'b0000, 0, 3'd0, 4'd0, 4'd0);
        drive(0, 1, 0, 4'd0, 1, 3'd2, 4'b1111, 4'b0000);
        drive(0, 0, 1, 4'b1111, 0, 3'd0, 4'd0, 4'd0);
        idle(3);

        // fill the counter, overflow, then drain
        for (int i = 0; i < 8; i++) drive(0, 1, 0, 4'd0, 0, 3'd0, 4'd0, 4'd0);
        for (int i = 0; i < 7; i++) drive(0, 0, 1, 4'(i), 0, 3'd0, 4'd0, 4'd0);
        idle(2);

        // simultaneous issue and writeback, then writeback at zero
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 4'd0, 0, 3'd0, 4'd0, 4'd0);
        drive(0, 1, 1, 4'b0101, 0, 3'd0, 4'd0, 4'd0);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 4'b0110, 0, 3'd0, 4'd0, 4'd0);
        drive(0, 0, 1, 4'b1010, 0, 3'd0, 4'd0, 4'd0);
        idle(2);

        // reset while a request is stalled
        drive(0, 1, 0, 4'd0, 0, 3'd0, 4'd0, 4'd0);
        drive(0, 0, 0, 4'd0, 1, 3'd4, 4'b0011, 4'b0001);
        idle(1);
        drive(1, 0, 0, 4'd0, 0, 3'd0, 4'd0, 4'd0);
        idle(3);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic r, iss, we;
            r   = ($urandom_range(0, 199) == 0);
            iss = ($urandom_range(0, 99) < 35);
            if (m_pend > 0) we = ($urandom_range(0, 99) < 40);
            else we = ($urandom_range(0, 99) < 5);
            drive(r, iss, we, 4'($urandom_range(0, 15)), ($urandom_range(0, 99) < 60),
                  3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
        end
        idle(4);
        check("exp_q_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
